pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. Watches the ID-stage source registers against EX/MEM-stage destinations and the MEM-stage branch outcome, then drives PC write-enable, IF/ID hold/flush, ID/EX bubble insertion and EX/MEM flush. It sits beside the decode stage and is the only block allowed to stall or squash pipeline registers.

## Interface
Parameters:
- `STALL_CNT_W`, 2, width of remaining-stall counter
- `PERF_STALL_W`, 32, stall-cycle performance counter width
- `PERF_FLUSH_W`, 16, flush-event performance counter width

Ports:
- `clk`  in  1  core clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `i_ID_valid`  in  1  ID holds a real instruction
- `i_ID_data_RSAddr` / `i_ID_data_RTAddr`  in  5 each  decoded source register addresses
- `i_ID_ctrl_UsesRS` / `i_ID_ctrl_UsesRT`  in  1 each  instruction actually reads RS / RT
- `i_EX_ctrl_RegWrite`, `i_EX_ctrl_MemRead`  in  1 each  EX-stage instruction writes a register / is a load
- `i_EX_data_DstAddr`  in  5  EX-stage destination (after RegDst mux)
- `i_MEM_ctrl_RegWrite`  in  1  MEM-stage instruction writes a register
- `i_MEM_data_DstAddr`  in  5  MEM-stage destination
- `i_MEM_ctrl_BranchTaken`  in  1  branch resolved taken in MEM
- `o_IF_ctrl_PCWrite`  out  1  PC register update enable
- `o_ID_ctrl_IFIDWrite`  out  1  IF/ID register update enable
- `o_ID_ctrl_IFIDFlush`  out  1  load NOP into IF/ID
- `o_EX_ctrl_Bubble`  out  1  zero all control fields entering ID/EX
- `o_MEM_ctrl_Flush`  out  1  zero control fields entering EX/MEM
- `o_state`  out  2  FSM state (RUN=0, STALL=1, FLUSH=2)
- `o_perf_StallCycles`  out  PERF_STALL_W  saturating count of stall cycles
- `o_perf_Flushes`  out  PERF_FLUSH_W  saturating count of taken-branch flushes

## Operation
- Hazard match: `i_ID_valid` & producer RegWrite & DstAddr≠0 & ((UsesRS & RSAddr==DstAddr) | (UsesRT & RTAddr==DstAddr)). Register 0 never hazards.
- Required stall length N: see Configuration. N computed combinationally from current inputs; the detection cycle is the first stall cycle.
- RUN: N=0 → PCWrite=1, IFIDWrite=1, all flush/bubble 0. N≥1 → PCWrite=0, IFIDWrite=0, Bubble=1; if N>1 go STALL with counter=N−1, else stay RUN.
- STALL: same stall outputs; counter decrements each cycle; counter reaching 1→ next state RUN after this cycle. Hazard re-evaluation suppressed while in STALL.
- Branch taken (any state, highest priority): IFIDFlush=1, Bubble=1, MEM Flush=1, PCWrite=1 (redirect loads), IFIDWrite=1; counter cleared; next state FLUSH.
- FLUSH: one cycle; IFIDFlush=1 to squash the wrong-path word returned by synchronous instruction memory; PCWrite=1; hazard detection masked (ID holds a NOP); next RUN unless another branch taken.
- Perf counters: StallCycles +1 each cycle PCWrite=0; Flushes +1 per taken branch; both saturate at all-ones.

## Timing
- Control outputs combinational from state, counter and inputs; no added latency.
- State, counter, perf counters registered.
- While `rst`=1: state RUN, counter 0, perf counters 0; outputs PCWrite=0, IFIDWrite=0, IFIDFlush=1, Bubble=1, MEM Flush=1. First cycle after deassert: normal RUN outputs.
- Reset mid-STALL/FLUSH: abandoned immediately, no residual stall.
- Branch taken in the same cycle as a hazard: branch wins, no stall cycle.

## Configuration
- `MIPS_PIPE_FORWARD_EN` defined: forwarding unit present; N=1 only for EX producer with MemRead (load-use); ALU producers N=0; MEM producers N=0.
- Undefined: no forwarding; EX producer match N=2, else MEM producer match N=1 (register file writes first half-cycle, so WB never hazards).

## Structure
- Shared package: FSM state enum (RUN/STALL/FLUSH), stall-length constants (LOAD_USE_STALL=1, EX_RAW_STALL=2, MEM_RAW_STALL=1).
- One sub-module `hazard_match`: combinational source/destination compare returning match flags; instantiated for EX and MEM producers.

## Test plan
- No hazard, ID reads $3, EX writes $5 → PCWrite=1, Bubble=0 every cycle, StallCycles stays 0.
- Load $4 in EX, ID reads RT=$4: with FORWARD_EN → exactly 1 cycle PCWrite=0/Bubble=1; without → 2 cycles, state goes STALL.
- ALU writes $0 in EX, ID reads $0 → no stall in either build.
- Branch taken in MEM during STALL (counter=1) → same cycle IFIDFlush=Bubble=MEM Flush=1, next state FLUSH, then RUN; Flushes=1.
- Back-to-back taken branches on consecutive cycles → FLUSH held two cycles, Flushes=2.
- Assert `rst` mid-STALL → outputs go to reset values asynchronously; after release state RUN, counters 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared definitions for the pipeline sequencing controller:
//   - state_e        : controller FSM state (RUN / STALL / FLUSH)
//   - *_STALL        : stall lengths for the different RAW hazard sources
//   - src_hits_dst() : source/destination register compare used by
//                      hazard_match
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Stall cycles needed before the consumer in ID may proceed.
  localparam int unsigned LOAD_USE_STALL = 1;  // load in EX, forwarding present
  localparam int unsigned EX_RAW_STALL   = 2;  // EX producer, no forwarding
  localparam int unsigned MEM_RAW_STALL  = 1;  // MEM producer, no forwarding

  // True when a real consumer reads a register that the producer will write.
  // Register $0 is hard-wired to zero and therefore never creates a hazard.
  function automatic logic src_hits_dst(
    input logic       valid,
    input logic       uses_rs,
    input logic       uses_rt,
    input logic [4:0] rs_addr,
    input logic [4:0] rt_addr,
    input logic       reg_write,
    input logic [4:0] dst_addr
  );
    logic rs_hit;
    logic rt_hit;
    rs_hit = uses_rs && (rs_addr == dst_addr);
    rt_hit = uses_rt && (rt_addr == dst_addr);
    return valid && reg_write && (dst_addr != 5'd0) && (rs_hit || rt_hit);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_match.sv
// ---------------------------------------------------------------------------
// hazard_match
// Combinational compare of the ID-stage source registers against one
// producer stage's destination register.
// Ports:
//   valid_i            ID holds a real instruction
//   uses_rs_i/uses_rt_i instruction actually reads RS / RT
//   rs_addr_i/rt_addr_i decoded source register addresses
//   reg_write_i        producer writes a register
//   dst_addr_i         producer destination register
//   hit_o              RAW hazard against this producer
// ---------------------------------------------------------------------------
module hazard_match
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic       valid_i,
  input  logic       uses_rs_i,
  input  logic       uses_rt_i,
  input  logic [4:0] rs_addr_i,
  input  logic [4:0] rt_addr_i,
  input  logic       reg_write_i,
  input  logic [4:0] dst_addr_i,
  output logic       hit_o
);

  assign hit_o = src_hits_dst(valid_i, uses_rs_i, uses_rt_i, rs_addr_i,
                              rt_addr_i, reg_write_i, dst_addr_i);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Pipeline sequencing controller for the 5-stage MIPS core. Detects RAW
// hazards between ID sources and EX/MEM destinations, handles taken-branch
// squashes resolved in MEM, and drives the pipeline-register enables/flushes.
//
// Build option: MIPS_PIPE_FORWARD_EN
//   defined   - forwarding unit present; only a load in EX stalls (1 cycle)
//   undefined - no forwarding; EX producer stalls 2, MEM producer stalls 1
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   i_ID_*                   ID-stage validity, source addresses, source use
//   i_EX_*                   EX-stage RegWrite, MemRead, destination
//   i_MEM_*                  MEM-stage RegWrite, destination, branch taken
//   o_IF_ctrl_PCWrite        PC update enable
//   o_ID_ctrl_IFIDWrite      IF/ID update enable
//   o_ID_ctrl_IFIDFlush      load NOP into IF/ID
//   o_EX_ctrl_Bubble         zero control entering ID/EX
//   o_MEM_ctrl_Flush         zero control entering EX/MEM
//   o_state                  FSM state (RUN=0, STALL=1, FLUSH=2)
//   o_perf_StallCycles       saturating count of cycles with PCWrite=0
//   o_perf_Flushes           saturating count of taken-branch flushes
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned STALL_CNT_W  = 2,
  parameter int unsigned PERF_STALL_W = 32,
  parameter int unsigned PERF_FLUSH_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_ID_valid,
  input  logic [4:0]              i_ID_data_RSAddr,
  input  logic [4:0]              i_ID_data_RTAddr,
  input  logic                    i_ID_ctrl_UsesRS,
  input  logic                    i_ID_ctrl_UsesRT,
  input  logic                    i_EX_ctrl_RegWrite,
  input  logic                    i_EX_ctrl_MemRead,
  input  logic [4:0]              i_EX_data_DstAddr,
  input  logic                    i_MEM_ctrl_RegWrite,
  input  logic [4:0]              i_MEM_data_DstAddr,
  input  logic                    i_MEM_ctrl_BranchTaken,
  output logic                    o_IF_ctrl_PCWrite,
  output logic                    o_ID_ctrl_IFIDWrite,
  output logic                    o_ID_ctrl_IFIDFlush,
  output logic                    o_EX_ctrl_Bubble,
  output logic                    o_MEM_ctrl_Flush,
  output logic [1:0]              o_state,
  output logic [PERF_STALL_W-1:0] o_perf_StallCycles,
  output logic [PERF_FLUSH_W-1:0] o_perf_Flushes
);

  localparam logic [STALL_CNT_W-1:0]  CNT_ONE   = STALL_CNT_W'(1);
  localparam logic [PERF_STALL_W-1:0] PS_ONE    = PERF_STALL_W'(1);
  localparam logic [PERF_FLUSH_W-1:0] PF_ONE    = PERF_FLUSH_W'(1);
  localparam logic [PERF_STALL_W-1:0] PS_SAT    = {PERF_STALL_W{1'b1}};
  localparam logic [PERF_FLUSH_W-1:0] PF_SAT    = {PERF_FLUSH_W{1'b1}};

  state_e                   state_q, state_d;
  logic [STALL_CNT_W-1:0]   cnt_q, cnt_d;
  logic [PERF_STALL_W-1:0]  perf_stall_q;
  logic [PERF_FLUSH_W-1:0]  perf_flush_q;

  logic                     ex_hit_s;
  logic                     mem_hit_s;
  logic [STALL_CNT_W-1:0]   stall_len_s;
  logic                     pc_write_s;
  logic                     ifid_write_s;
  logic                     ifid_flush_s;
  logic                     bubble_s;
  logic                     mem_flush_s;

  hazard_match u_ex_match (
    .valid_i     (i_ID_valid),
    .uses_rs_i   (i_ID_ctrl_UsesRS),
    .uses_rt_i   (i_ID_ctrl_UsesRT),
    .rs_addr_i   (i_ID_data_RSAddr),
    .rt_addr_i   (i_ID_data_RTAddr),
    .reg_write_i (i_EX_ctrl_RegWrite),
    .dst_addr_i  (i_EX_data_DstAddr),
    .hit_o       (ex_hit_s)
  );

  hazard_match u_mem_match (
    .valid_i     (i_ID_valid),
    .uses_rs_i   (i_ID_ctrl_UsesRS),
    .uses_rt_i   (i_ID_ctrl_UsesRT),
    .rs_addr_i   (i_ID_data_RSAddr),
    .rt_addr_i   (i_ID_data_RTAddr),
    .reg_write_i (i_MEM_ctrl_RegWrite),
    .dst_addr_i  (i_MEM_data_DstAddr),
    .hit_o       (mem_hit_s)
  );

  // Stall length demanded by the instruction currently in ID.
  always_comb begin
    stall_len_s = '0;
`ifdef MIPS_PIPE_FORWARD_EN
    // Forwarding covers ALU results; only load-use must wait for memory data.
    if (ex_hit_s && i_EX_ctrl_MemRead) begin
      stall_len_s = STALL_CNT_W'(LOAD_USE_STALL);
    end else begin
      stall_len_s = '0;
    end
`else
    // Register file writes in the first half-cycle, so WB never hazards.
    if (ex_hit_s) begin
      stall_len_s = STALL_CNT_W'(EX_RAW_STALL);
    end else if (mem_hit_s) begin
      stall_len_s = STALL_CNT_W'(MEM_RAW_STALL);
    end else begin
      stall_len_s = '0;
    end
`endif
  end

  // Control outputs and next-state logic; taken branch overrides everything.
  always_comb begin
    pc_write_s   = 1'b1;
    ifid_write_s = 1'b1;
    ifid_flush_s = 1'b0;
    bubble_s     = 1'b0;
    mem_flush_s  = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    if (rst) begin
      // Hold the whole pipeline quiet while reset is asserted.
      pc_write_s   = 1'b0;
      ifid_write_s = 1'b0;
      ifid_flush_s = 1'b1;
      bubble_s     = 1'b1;
      mem_flush_s  = 1'b1;
      state_d      = ST_RUN;
      cnt_d        = '0;
    end else if (i_MEM_ctrl_BranchTaken) begin
      // PC/IF-ID stay enabled so the redirect target is loaded.
      ifid_flush_s = 1'b1;
      bubble_s     = 1'b1;
      mem_flush_s  = 1'b1;
      state_d      = ST_FLUSH;
      cnt_d        = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (stall_len_s != '0) begin
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            bubble_s     = 1'b1;
            // Detection cycle counts as the first stall cycle.
            if (stall_len_s > CNT_ONE) begin
              state_d = ST_STALL;
              cnt_d   = stall_len_s - CNT_ONE;
            end else begin
              state_d = ST_RUN;
              cnt_d   = '0;
            end
          end else begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
        ST_STALL: begin
          // Hazard inputs are ignored here: the count already covers them.
          pc_write_s   = 1'b0;
          ifid_write_s = 1'b0;
          bubble_s     = 1'b1;
          if (cnt_q <= CNT_ONE) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            state_d = ST_STALL;
            cnt_d   = cnt_q - CNT_ONE;
          end
        end
        ST_FLUSH: begin
          // Squash the wrong-path word from synchronous instruction memory.
          ifid_flush_s = 1'b1;
          state_d      = ST_RUN;
          cnt_d        = '0;
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM state and remaining-stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (!pc_write_s && (perf_stall_q != PS_SAT)) begin
        perf_stall_q <= perf_stall_q + PS_ONE;
      end else begin
        perf_stall_q <= perf_stall_q;
      end
      if (i_MEM_ctrl_BranchTaken && (perf_flush_q != PF_SAT)) begin
        perf_flush_q <= perf_flush_q + PF_ONE;
      end else begin
        perf_flush_q <= perf_flush_q;
      end
    end
  end

  assign o_IF_ctrl_PCWrite   = pc_write_s;
  assign o_ID_ctrl_IFIDWrite = ifid_write_s;
  assign o_ID_ctrl_IFIDFlush = ifid_flush_s;
  assign o_EX_ctrl_Bubble    = bubble_s;
  assign o_MEM_ctrl_Flush    = mem_flush_s;
  assign o_state             = state_q;
  assign o_perf_StallCycles  = perf_stall_q;
  assign o_perf_Flushes      = perf_flush_q;

endmodule
